csa_cpa_pipe2: RTL and testbench

//  Final carry-propagate stage behind the 3:2 CSA compressor (S/Cout redundant pair).

---
 rtl/csa_cpa_pipe2.sv | 73 +++++++
 tb/tb_csa_cpa_pipe2.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_cpa_pipe2.sv
// rtl/csa_cpa_pipe2.sv - two-stage elastic carry-propagate adder resolving a CSA sum/carry pair
module csa_cpa_pipe2 #(
  parameter int W     = 14,
  parameter int SPLIT = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:1]   S_in,
  input  logic [W:1]   C_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:1] sum
);

  logic             s1_valid;
  logic             s2_valid;
  logic [SPLIT:1]   lo_sum;
  logic             c_split;
  logic [W:SPLIT+1] s_hi;
  logic [W:SPLIT+1] c_hi;

  logic             accept;
  logic             s2_adv;
  logic [SPLIT:0]   lo_full;
  logic [W-SPLIT:0] hi_full;

  // in_ready depends only on registered state and out_ready, never on in_valid
  assign s2_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign lo_full = {1'b0, S_in[SPLIT:1]} + {1'b0, C_in[SPLIT:1]};
  assign hi_full = {1'b0, s_hi} + {1'b0, c_hi} + {{(W-SPLIT){1'b0}}, c_split};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      lo_sum   <= '0;
      c_split  <= 1'b0;
      s_hi     <= '0;
      c_hi     <= '0;
    end else begin
      if (accept) begin
        lo_sum   <= lo_full[SPLIT-1:0];
        c_split  <= lo_full[SPLIT];
        s_hi     <= S_in[W:SPLIT+1];
        c_hi     <= C_in[W:SPLIT+1];
        s1_valid <= 1'b1;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // sum is only written on advance, so it holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
    end else begin
      if (s2_adv) begin
        sum      <= {hi_full, lo_sum};
        s2_valid <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_cpa_pipe2.sv
// tb/tb_csa_cpa_pipe2.sv - self-checking bench for csa_cpa_pipe2 with queue-based sum model
module tb_csa_cpa_pipe2;

  localparam int W     = 14;
  localparam int SPLIT = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W:1]   S_in;
  logic [W:1]   C_in;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:1] sum;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int cyc   = 0;
  logic [W+1:1] expq[$];

  csa_cpa_pipe2 #(.W(W), .SPLIT(SPLIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .S_in(S_in), .C_in(C_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: every accepted pair must come out as its plain unsigned sum, in order
  logic         stall_prev = 1'b0;
  logic [W+1:1] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum", 32'(sum), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("unexpected_output", 32'(sum), 32'hFFFF_FFFF);
        else check("scoreboard_sum", 32'(sum), 32'(expq.pop_front()));
        n_out++;
      end
      if (in_valid && in_ready)
        expq.push_back({1'b0, S_in} + {1'b0, C_in});
      stall_prev = out_valid && !out_ready;
      held       = sum;
    end
  end

  // Called just after a posedge; returns just after the edge that accepted the pair
  task automatic send(input logic [W:1] s, input logic [W:1] c);
    logic rdy;
    int   n;
    in_valid = 1'b1;
    S_in     = s;
    C_in     = c;
    n        = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 1000);
    if (!rdy) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, c0, sent, guard;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; S_in = '0; C_in = '0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(1);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // single op, carry crosses the split; latency two cycles
    out_ready = 1'b1;
    send(14'h007F, 14'h0001);
    in_valid = 1'b0;
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    wait_cycles(1);
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("single_sum", 32'(sum), 32'h0080);

    // max operands
    send(14'h3FFF, 14'h3FFF);
    in_valid = 1'b0;
    wait_cycles(1);
    check("max_sum", 32'(sum), 32'h7FFE);
    send(14'h3FFF, 14'h0001);
    in_valid = 1'b0;
    wait_cycles(1);
    check("max_plus1_sum", 32'(sum), 32'h4000);
    wait_cycles(2);

    // back-to-back
    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(W'($urandom_range(0, 16383)), W'($urandom_range(0, 16383)));
    in_valid = 1'b0;
    check("b2b_accept_cycles", 32'(cyc - c0), 32'd8);
    wait_cycles(2);
    check("b2b_outputs", 32'(n_out - n0), 32'd8);
    wait_cycles(2);

    // backpressure: A,B fill the pipe, C must wait
    out_ready = 1'b0;
    n0 = n_out;
    send(14'h0001, 14'h0002);
    send(14'h1000, 14'h0800);
    S_in = 14'h2AAA;
    C_in = 14'h1555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_sum_a", 32'(sum), 32'h0003);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(14'h2AAA, 14'h1555);
    in_valid = 1'b0;
    wait_cycles(5);
    check("bp_outputs", 32'(n_out - n0), 32'd3);

    // reset mid-flight
    out_ready = 1'b0;
    send(14'h0123, 14'h0456);
    send(14'h0789, 14'h0ABC);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    wait_cycles(5);
    check("midrst_no_stale", 32'(n_out - n0), 32'd0);
    send(14'h0100, 14'h0100);
    in_valid = 1'b0;
    wait_cycles(1);
    check("post_rst_sum", 32'(sum), 32'h0200);
    wait_cycles(2);

    // random traffic with toggling valid/ready
    sent  = 0;
    guard = 0;
    n0    = n_out;
    S_in  = W'($urandom_range(0, 16383));
    C_in  = W'($urandom_range(0, 16383));
    while (sent < 10000 && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        sent++;
        S_in = W'($urandom_range(0, 16383));
        C_in = W'($urandom_range(0, 16383));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_all_sent", 32'(sent), 32'd10000);
    guard = 0;
    while (expq.size() != 0 && guard < 100) begin
      wait_cycles(1);
      guard++;
    end
    wait_cycles(2);
    check("rand_drained", 32'(expq.size()), 32'd0);
    check("rand_outputs", 32'(n_out - n0), 32'd10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
